// File: rtl/pt2272_frame_ctrl.sv
`timescale 1ns/1ps
// PT2272 frame controller: assembles address/data symbol frames, checks them against
// the local trinary address and latches D after REPEAT_N identical valid frames.
module pt2272_frame_ctrl #(
    parameter int ADDR_SYMS   = 8,
    parameter int DATA_SYMS   = 4,
    parameter int REPEAT_N    = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sym_valid,
    input  logic [1:0]             sym,
    input  logic [2*ADDR_SYMS-1:0] addr_i,
    output logic [DATA_SYMS-1:0]   D,
    output logic                   dv,
    output logic                   new_data,
    output logic                   frame_err,
    output logic [1:0]             state_dbg
);

    // Handshake: sym_valid is a one-cycle strobe with no back-pressure; sym is only
    // meaningful in the cycle sym_valid is high and every strobe is consumed.

    localparam int FRAME_SYMS = ADDR_SYMS + DATA_SYMS;
    localparam int CNT_W      = $clog2(FRAME_SYMS + 1);
    localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int REP_W      = $clog2(REPEAT_N + 1);

    localparam logic [1:0] SYM_0    = 2'b00;
    localparam logic [1:0] SYM_1    = 2'b11;
    localparam logic [1:0] SYM_SYNC = 2'b01;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        COLLECT   = 2'd1,
        WAIT_SYNC = 2'd2,
        CHECK     = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     sym_cnt, sym_cnt_n;
    logic [REP_W-1:0]     rep_cnt, rep_n;
    logic [TMO_W-1:0]     tmo_cnt, tmo_n;
    logic [DATA_SYMS-1:0] prev_data, prev_n;
    logic [DATA_SYMS-1:0] d_n;
    logic                 dv_n, new_data_n, frame_err_n;
    logic [1:0]           frame_q [FRAME_SYMS];

    logic                 buf_we;
    logic [CNT_W-1:0]     buf_idx;
    logic                 do_collect;
    logic [CNT_W-1:0]     col_cnt;
    logic                 tmo_expire;

    logic                 addr_ok, data_ok;
    logic [DATA_SYMS-1:0] frame_data;

    assign state_dbg = state;

    // Frame qualification works directly on the stored symbols; SYNC is never
    // stored, so an addr_i slice of 01 can never match.
    always_comb begin
        addr_ok    = 1'b1;
        data_ok    = 1'b1;
        frame_data = '0;
        for (int i = 0; i < ADDR_SYMS; i++) begin
            if (frame_q[i] != addr_i[2*i +: 2]) addr_ok = 1'b0;
        end
        for (int k = 0; k < DATA_SYMS; k++) begin
            if (frame_q[ADDR_SYMS+k] != SYM_0 && frame_q[ADDR_SYMS+k] != SYM_1) data_ok = 1'b0;
            frame_data[k] = frame_q[ADDR_SYMS+k][0];
        end
    end

    always_comb begin
        if (sym_valid) begin
            tmo_n = '0;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
            tmo_n = tmo_cnt;
        end else begin
            tmo_n = tmo_cnt + TMO_W'(1);
        end
        tmo_expire = !sym_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) && (state != HUNT);
    end

    always_comb begin
        state_n     = state;
        sym_cnt_n   = sym_cnt;
        rep_n       = rep_cnt;
        prev_n      = prev_data;
        d_n         = D;
        dv_n        = dv;
        new_data_n  = 1'b0;
        frame_err_n = 1'b0;
        buf_we      = 1'b0;
        buf_idx     = sym_cnt;
        do_collect  = 1'b0;
        col_cnt     = sym_cnt;

        case (state)
            HUNT: begin
                if (sym_valid && sym == SYM_SYNC) begin
                    state_n   = COLLECT;
                    sym_cnt_n = '0;
                end
            end
            COLLECT: begin
                do_collect = 1'b1;
            end
            WAIT_SYNC: begin
                if (sym_valid) begin
                    if (sym == SYM_SYNC) begin
                        state_n = CHECK;
                    end else begin
                        frame_err_n = 1'b1;
                        rep_n       = '0;
                        dv_n        = 1'b0;
                        state_n     = HUNT;
                    end
                end
            end
            CHECK: begin
                if (!(addr_ok && data_ok)) begin
                    frame_err_n = 1'b1;
                    rep_n       = '0;
                    dv_n        = 1'b0;
                end else begin
                    if (rep_cnt != '0 && frame_data == prev_data) begin
                        rep_n = (rep_cnt == REP_W'(REPEAT_N)) ? rep_cnt : rep_cnt + REP_W'(1);
                    end else begin
                        rep_n  = REP_W'(1);
                        prev_n = frame_data;
                    end
                    if (rep_n == REP_W'(REPEAT_N)) begin
                        new_data_n = (frame_data != D) || !dv;
                        d_n        = frame_data;
                        dv_n       = 1'b1;
                    end
                end
                // The SYNC that ended this frame already opened the next one.
                state_n    = COLLECT;
                sym_cnt_n  = '0;
                do_collect = 1'b1;
                col_cnt    = '0;
            end
            default: state_n = HUNT;
        endcase

        if (do_collect && sym_valid) begin
            if (sym == SYM_SYNC) begin
                if (col_cnt != '0) begin
                    frame_err_n = 1'b1;
                    rep_n       = '0;
                    dv_n        = 1'b0;
                end
                sym_cnt_n = '0;
                state_n   = COLLECT;
            end else begin
                buf_we    = 1'b1;
                buf_idx   = col_cnt;
                sym_cnt_n = col_cnt + CNT_W'(1);
                state_n   = (col_cnt == CNT_W'(FRAME_SYMS - 1)) ? WAIT_SYNC : COLLECT;
            end
        end

        // Losing the stream drops validity but D keeps its last latched value.
        if (tmo_expire) begin
            state_n = HUNT;
            dv_n    = 1'b0;
            rep_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            sym_cnt   <= '0;
            rep_cnt   <= '0;
            tmo_cnt   <= '0;
            prev_data <= '0;
            D         <= '0;
            dv        <= 1'b0;
            new_data  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < FRAME_SYMS; i++) frame_q[i] <= 2'b00;
        end else begin
            state     <= state_n;
            sym_cnt   <= sym_cnt_n;
            rep_cnt   <= rep_n;
            tmo_cnt   <= tmo_n;
            prev_data <= prev_n;
            D         <= d_n;
            dv        <= dv_n;
            new_data  <= new_data_n;
            frame_err <= frame_err_n;
            if (buf_we) frame_q[buf_idx] <= sym;
        end
    end

endmodule
